// File: rtl/fp_pkg.sv
// +------------------------------------------------------------------+
// | fp_pkg: shared single-precision adder types and constants        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } norm_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_normalizer_if.sv
// +------------------------------------------------------------------+
// | fp_normalizer_if: ALU-sum input and packed-result handshakes      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface fp_normalizer_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic                    in_carry;
    logic [EXP_W-1:0]        in_exp;
    logic [MANT_W:0]         in_mant;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+MANT_W:0]   result;
    logic                    overflow;

    // Normalizer side
    modport slave (
        input  in_valid, in_sign, in_carry, in_exp, in_mant, out_ready,
        output in_ready, out_valid, result, overflow
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_sign, in_carry, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, result, overflow
    );
endinterface

`default_nettype wire

// File: rtl/fp_normalizer.sv
// +------------------------------------------------------------------+
// | fp_normalizer: iterative post-ALU normalization to binary32       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module fp_normalizer
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fp_normalizer_if.slave  bus
);

    localparam int               c_MW       = MANT_W + 1;
    localparam logic [EXP_W-1:0] c_EXP_MAX  = '1;
    localparam logic [EXP_W-1:0] c_EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

    norm_state_t               r_state;
    logic                      r_sign;
    logic                      r_carry;
    logic [EXP_W-1:0]          r_exp;
    logic [c_MW-1:0]           r_mant;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [EXP_W+MANT_W:0]     r_result;
    logic                      r_overflow;

    norm_state_t               w_next_state;
    logic                      w_sign;
    logic                      w_carry;
    logic [EXP_W-1:0]          w_exp;
    logic [EXP_W-1:0]          w_exp_inc;
    logic [c_MW-1:0]           w_mant;
    logic                      w_ovf;

    assign w_exp_inc = r_exp + c_EXP_ONE;

    // One normalization action per NORM cycle, first matching rule wins
    always_comb begin
        w_next_state = r_state;
        w_sign       = r_sign;
        w_carry      = r_carry;
        w_exp        = r_exp;
        w_mant       = r_mant;
        w_ovf        = 1'b0;
        if (r_state == ST_NORM) begin
            if (r_exp == c_EXP_MAX) begin
                w_next_state = ST_DONE;
            end else if (r_carry) begin
                w_mant       = {1'b1, r_mant[c_MW-1:1]};
                w_exp        = w_exp_inc;
                w_carry      = 1'b0;
                if (w_exp_inc == c_EXP_MAX) begin
                    w_mant[MANT_W-1:0] = '0;
                    w_ovf              = 1'b1;
                end
                w_next_state = ST_DONE;
            end else if (r_mant == '0) begin
                w_sign       = 1'b0;
                w_exp        = '0;
                w_next_state = ST_DONE;
            end else if (r_mant[c_MW-1]) begin
                w_next_state = ST_DONE;
            end else if (r_exp <= c_EXP_ONE) begin
                // Exponent floor reached: emit as subnormal without further shifting
                w_exp        = '0;
                w_next_state = ST_DONE;
            end else begin
                w_mant       = r_mant << 1;
                w_exp        = r_exp - c_EXP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sign      <= 1'b0;
            r_carry     <= 1'b0;
            r_exp       <= '0;
            r_mant      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign     <= bus.in_sign;
                        r_carry    <= bus.in_carry;
                        r_exp      <= bus.in_exp;
                        r_mant     <= bus.in_mant;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    r_sign  <= w_sign;
                    r_carry <= w_carry;
                    r_exp   <= w_exp;
                    r_mant  <= w_mant;
                    r_state <= w_next_state;
                    if (w_next_state == ST_DONE) begin
                        r_out_valid <= 1'b1;
                        r_result    <= {w_sign, w_exp, w_mant[MANT_W-1:0]};
                        r_overflow  <= w_ovf;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/fp_normalizer.md
# fp_normalizer

Normalization stage of the single-precision floating-point adder, directly downstream of the mantissa ALU. Takes the ALU's signed sum (sign, carry-out, 24-bit mantissa with explicit leading bit) plus the common exponent from alignment. Normalizes iteratively, one left shift per cycle, or with a single right shift on carry-out. Emits a packed IEEE-754 binary32 result over a valid/ready handshake.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MANT_W`, default 23: stored fraction width; the datapath mantissa is `MANT_W+1` bits.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: input bundle valid.
- `in_ready`, output, 1: stage can accept.
- `in_sign`, input, 1: ALU result sign.
- `in_carry`, input, 1: ALU carry-out.
- `in_exp`, input, `EXP_W`: common (larger) biased exponent.
- `in_mant`, input, `MANT_W+1`: ALU magnitude; bit 23 is the integer bit.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts.
- `result`, output, 32: packed {sign, exp, frac}.
- `overflow`, output, 1: result rounded to ±Inf; qualified by `out_valid`.

## Operation
- FSM states: IDLE, NORM, DONE.
- IDLE
  - `in_ready=1`.
  - On `in_valid`: capture sign, carry, exp, mant into working registers; go to NORM.
- NORM: exactly one action per edge, evaluated in this priority order:
  1. `exp==8'hFF`: pass through unchanged (Inf/NaN is handled upstream) → DONE.
  2. `carry`: mant = {1, mant[23:1]} (truncate the dropped bit), exp+1.
     - If the new exp is `8'hFF`: frac=0, `overflow=1`.
     - Go to DONE.
  3. `mant==0`: result = +0 (sign forced to 0) → DONE.
  4. `mant[23]==1`: → DONE.
  5. `exp<=1`: subnormal. exp field=0, mant unshifted → DONE.
  6. Otherwise: mant <<= 1, exp−1; stay in NORM.
- DONE
  - `out_valid=1`.
  - `result`={sign, exp, mant[22:0]}, held stable until `out_ready`.
  - On `out_valid && out_ready` → IDLE.
- Truncation only; there is no rounding logic in this stage.
- The exponent never wraps: decrement is blocked at 1 (rule 5) and increment saturates at `8'hFF` (rule 2).

## Timing
- Reset values:
  - state=IDLE, `in_ready=1`, `out_valid=0`, `result=32'h0`, `overflow=0`.
  - All working registers are 0.
- Reset asserted in any state (including mid-NORM or DONE): the in-flight operand is discarded and the reset values apply from the next edge.
- Latency: acceptance edge E0 → `out_valid` high after edge E0+1+k.
  - k = number of left shifts performed (0..23).
  - Carry, zero and already-normalized inputs: k=0.
- Throughput: one operation in flight. `in_ready=0` in NORM and DONE.
- `in_ready` is registered state, not combinational from `out_ready`. The earliest the next acceptance can occur is the edge after the output handshake.
- `in_*` are sampled only on the acceptance edge; they may change freely at other times.

## Structure
- Shared package `fp_pkg`:
  - `EXP_W`, `MANT_W`, `EXP_MAX` (8'hFF).
  - `typedef struct packed fp32_t {sign, exp, frac}`.
  - Normalizer state enum.
  - The same package is used by the alignment and ALU stages.
- No sub-module: the iterative shifter replaces a leading-zero counter. Single always_ff FSM plus a combinational next-state/next-data block.

## Test plan
- Carry: sign=1, carry=1, exp=8'h80, mant=24'hB42000 → result=32'hC0DA1000, overflow=0, `out_valid` at E0+1.
- Already normalized: sign=0, carry=0, exp=8'h7F, mant=24'h800000 → 32'h3F800000 at E0+1.
- Left shift: exp=8'h80, mant=24'h200000 → 32'h3F000000 at E0+3.
- Subnormal: exp=8'h01, mant=24'h400000 → 32'h00400000 at E0+1.
- Cancellation and overflow:
  - sign=1, mant=0, carry=0 → 32'h00000000.
  - carry=1, exp=8'hFE, sign=0 → 32'h7F800000 with overflow=1.
- Backpressure and reset:
  - Hold `out_ready=0` for 5 cycles: `result` and `out_valid` stable, `in_ready=0`.
  - Assert `reset` during NORM of a k=5 case: next edge `out_valid=0`, `in_ready=1`, `result=0`.
  - The next operation completes correctly.
